// File: rtl/uart_tx_framer.sv
// ---------------------------------------------------------------------------
// uart_tx_framer
//
// Transmit-side UART serializer with acknowledge/retry. A word accepted over
// a valid/ready handshake is framed as: start bit (0), WORD_LENGTH data bits
// LSB first, odd parity bit, stop bit (1). Each symbol lasts BAUD_DIV clocks.
// After the stop bit the line idles high for ACK_WINDOW clocks while the
// synchronized err_ack is watched; any error seen in that window causes the
// same word to be resent, up to MAX_RETRY times.
//
// Handshake: a word transfers on a rising t_clk edge where tx_valid and
// tx_ready are both 1. tx_ready is 1 only in IDLE; tx_valid is ignored in
// every other state, and tx_data only needs to be stable at the transfer edge.
//
// Ports:
//   t_clk        transmit clock
//   t_rst_n      asynchronous active-low reset
//   tx_data      word to send
//   tx_valid     tx_data is valid
//   tx_ready     block can accept a word (registered)
//   err_ack      receiver status, async: 1 = packet not OK, 0 = OK
//   UART_Tx_OUT  serial line, idle high (registered)
//   tx_busy      frame or ack window in progress (registered)
//   tx_done      one-cycle pulse: word acknowledged OK (registered)
//   tx_fail      one-cycle pulse: word abandoned after MAX_RETRY retries
//   retry_cnt    retransmissions made for the current word (registered)
//   o_dbg_state  current FSM state encoding, for debug/checkers
// ---------------------------------------------------------------------------
module uart_tx_framer #(
    parameter int WORD_LENGTH = 8,
    parameter int CLK_RATE    = 50000000,
    parameter int BAUD        = 115200,
    parameter int ACK_WINDOW  = 16,
    parameter int MAX_RETRY   = 2
) (
    input  logic                             t_clk,
    input  logic                             t_rst_n,
    input  logic [WORD_LENGTH-1:0]           tx_data,
    input  logic                             tx_valid,
    output logic                             tx_ready,
    input  logic                             err_ack,
    output logic                             UART_Tx_OUT,
    output logic                             tx_busy,
    output logic                             tx_done,
    output logic                             tx_fail,
    output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt,
    output logic [2:0]                       o_dbg_state
);

    localparam int BAUD_DIV = CLK_RATE / BAUD;
    localparam int BCW      = $clog2(BAUD_DIV);
    localparam int AW       = $clog2(ACK_WINDOW + 1);
    localparam int IW       = $clog2(WORD_LENGTH) + 1;
    localparam int RW       = $clog2(MAX_RETRY + 1);

    localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
    localparam logic [AW-1:0]  ACK_LAST  = AW'(ACK_WINDOW - 1);
    localparam logic [IW-1:0]  IDX_LAST  = IW'(WORD_LENGTH - 1);
    localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_DATA     = 3'd2,
        S_PARITY   = 3'd3,
        S_STOP     = 3'd4,
        S_ACK_WAIT = 3'd5
    } state_t;

    state_t                 r_state;
    logic [WORD_LENGTH-1:0] r_shadow;
    logic [BCW-1:0]         r_baud_cnt;
    logic [IW-1:0]          r_bit_idx;
    logic [AW-1:0]          r_ack_cnt;
    logic                   r_err_seen;
    logic                   r_err_meta;
    logic                   r_err_sync;

    logic                   w_baud_last;
    logic [IW-1:0]          w_next_idx;
    logic [WORD_LENGTH-1:0] w_shifted;
    logic                   w_parity;
    logic                   w_err_any;

    assign o_dbg_state = r_state;
    assign w_baud_last = (r_baud_cnt == BAUD_LAST);
    assign w_next_idx  = r_bit_idx + IW'(1);
    // Shift rather than index so the index width never has to match the word.
    assign w_shifted   = r_shadow >> w_next_idx;
    assign w_parity    = ~(^r_shadow);
    // Include this cycle's sample so an error on the last window cycle counts.
    assign w_err_any   = r_err_seen | r_err_sync;

    // Two-flop synchronizer for the receiver's asynchronous status line.
    always_ff @(posedge t_clk or negedge t_rst_n) begin
        if (!t_rst_n) begin
            r_err_meta <= 1'b0;
            r_err_sync <= 1'b0;
        end else begin
            r_err_meta <= err_ack;
            r_err_sync <= r_err_meta;
        end
    end

    always_ff @(posedge t_clk or negedge t_rst_n) begin
        if (!t_rst_n) begin
            r_state     <= S_IDLE;
            r_shadow    <= '0;
            r_baud_cnt  <= '0;
            r_bit_idx   <= '0;
            r_ack_cnt   <= '0;
            r_err_seen  <= 1'b0;
            UART_Tx_OUT <= 1'b1;
            tx_ready    <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            tx_fail     <= 1'b0;
            retry_cnt   <= '0;
        end else begin
            tx_done <= 1'b0;
            tx_fail <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_baud_cnt <= '0;
                    r_ack_cnt  <= '0;
                    if (tx_valid && tx_ready) begin
                        r_shadow    <= tx_data;
                        retry_cnt   <= '0;
                        r_state     <= S_START;
                        UART_Tx_OUT <= 1'b0;
                        tx_ready    <= 1'b0;
                        tx_busy     <= 1'b1;
                    end
                end

                S_START: begin
                    if (w_baud_last) begin
                        r_baud_cnt  <= '0;
                        r_bit_idx   <= '0;
                        r_state     <= S_DATA;
                        UART_Tx_OUT <= r_shadow[0];
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BCW'(1);
                    end
                end

                S_DATA: begin
                    if (w_baud_last) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == IDX_LAST) begin
                            r_state     <= S_PARITY;
                            UART_Tx_OUT <= w_parity;
                        end else begin
                            r_bit_idx   <= w_next_idx;
                            UART_Tx_OUT <= w_shifted[0];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BCW'(1);
                    end
                end

                S_PARITY: begin
                    if (w_baud_last) begin
                        r_baud_cnt  <= '0;
                        r_state     <= S_STOP;
                        UART_Tx_OUT <= 1'b1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BCW'(1);
                    end
                end

                S_STOP: begin
                    if (w_baud_last) begin
                        r_baud_cnt  <= '0;
                        r_ack_cnt   <= '0;
                        r_err_seen  <= 1'b0;
                        r_state     <= S_ACK_WAIT;
                        UART_Tx_OUT <= 1'b1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BCW'(1);
                    end
                end

                S_ACK_WAIT: begin
                    if (r_err_sync) begin
                        r_err_seen <= 1'b1;
                    end
                    if (r_ack_cnt == ACK_LAST) begin
                        r_ack_cnt <= '0;
                        if (!w_err_any) begin
                            tx_done  <= 1'b1;
                            tx_ready <= 1'b1;
                            tx_busy  <= 1'b0;
                            r_state  <= S_IDLE;
                        end else if (retry_cnt < RETRY_MAX) begin
                            // Resend the unchanged shadow word.
                            retry_cnt   <= retry_cnt + RW'(1);
                            r_state     <= S_START;
                            UART_Tx_OUT <= 1'b0;
                        end else begin
                            tx_fail  <= 1'b1;
                            tx_ready <= 1'b1;
                            tx_busy  <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end else begin
                        r_ack_cnt <= r_ack_cnt + AW'(1);
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    UART_Tx_OUT <= 1'b1;
                    tx_ready    <= 1'b1;
                    tx_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_framer
//
// Bench for uart_tx_framer with BAUD_DIV=4, ACK_WINDOW=8, MAX_RETRY=2.
// The driver pushes expected frames and expected outcomes (done/fail, retry
// count, completion cycle) into queues; a line monitor captures every frame
// off UART_Tx_OUT and a result monitor watches tx_done/tx_fail, each popping
// and comparing against the queues.
// ---------------------------------------------------------------------------
module tb_uart_tx_framer;

    localparam int WL    = 8;
    localparam int BD    = 4;
    localparam int AWIN  = 8;
    localparam int MR    = 2;
    localparam int FRAME = (WL + 3) * BD;
    localparam int TXN   = FRAME + AWIN;

    logic          t_clk = 1'b0;
    logic          t_rst_n = 1'b0;
    logic [WL-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          err_ack = 1'b0;
    logic          tx_ready;
    logic          UART_Tx_OUT;
    logic          tx_busy;
    logic          tx_done;
    logic          tx_fail;
    logic [1:0]    retry_cnt;
    logic [2:0]    dbg_state;

    uart_tx_framer #(
        .WORD_LENGTH(WL),
        .CLK_RATE   (400),
        .BAUD       (100),
        .ACK_WINDOW (AWIN),
        .MAX_RETRY  (MR)
    ) dut (
        .t_clk      (t_clk),
        .t_rst_n    (t_rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .err_ack    (err_ack),
        .UART_Tx_OUT(UART_Tx_OUT),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_fail    (tx_fail),
        .retry_cnt  (retry_cnt),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 t_clk = ~t_clk;

    int cyc = 0;
    always @(posedge t_clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int            n_cmp = 0;
    int            n_err = 0;
    logic [WL-1:0] exp_q[$];
    int            exp_kind_q[$];   // 1 = done, 2 = fail
    int            exp_retry_q[$];
    int            exp_cyc_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference line waveform of one frame: one sample per clock.
    function automatic logic [FRAME-1:0] frame_bits(input logic [WL-1:0] d);
        logic [FRAME-1:0] fb;
        int sym;
        fb = '0;
        for (int s = 0; s < WL + 3; s++) begin
            if (s == 0)            sym = 0;
            else if (s <= WL)      sym = int'((d >> (s - 1)) & 8'd1);
            else if (s == WL + 1)  sym = ($countones(d) % 2 == 0) ? 1 : 0;
            else                   sym = 1;
            for (int k = 0; k < BD; k++) fb[s*BD + k] = sym[0];
        end
        return fb;
    endfunction

    // ---------------- line monitor ----------------
    logic [FRAME-1:0] rx_bits = '0;
    int               rx_n = 0;
    logic             rx_active = 1'b0;
    logic             prev_line = 1'b1;
    logic [WL-1:0]    rx_exp_d;

    always @(negedge t_clk) begin
        if (!t_rst_n) begin
            rx_active = 1'b0;
            rx_n      = 0;
            prev_line = 1'b1;
        end else if (!rx_active) begin
            if (prev_line && !UART_Tx_OUT) begin
                rx_active  = 1'b1;
                rx_bits    = '0;
                rx_n       = 1;
            end
            prev_line = UART_Tx_OUT;
        end else begin
            rx_bits[rx_n] = UART_Tx_OUT;
            rx_n++;
            prev_line = UART_Tx_OUT;
            if (rx_n == FRAME) begin
                rx_active = 1'b0;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL frame: got unexpected frame %h, expected no frame", rx_bits);
                end else begin
                    rx_exp_d = exp_q.pop_front();
                    check("frame", 64'(rx_bits), 64'(frame_bits(rx_exp_d)));
                end
            end
        end
    end

    // ---------------- result monitor ----------------
    int r_kind, r_retry, r_cyc;
    always @(negedge t_clk) begin
        if (t_rst_n && (tx_done || tx_fail)) begin
            if (exp_kind_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL result: got done=%0b fail=%0b at cycle %0d, expected none", tx_done, tx_fail, cyc);
            end else begin
                r_kind  = exp_kind_q.pop_front();
                r_retry = exp_retry_q.pop_front();
                r_cyc   = exp_cyc_q.pop_front();
                check("result_kind", 64'({tx_fail, tx_done}), (r_kind == 1) ? 64'd1 : 64'd2);
                check("result_retry", 64'(retry_cnt), 64'(r_retry));
                check("result_cycle", 64'(cyc), 64'(r_cyc));
                check("result_ready", 64'(tx_ready), 64'd1);
                check("result_busy", 64'(tx_busy), 64'd0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge t_clk);
    endtask

    // Called at a negedge. nak = number of leading ack windows in which the
    // receiver reports an error (err_off<0 picks a random position); hold
    // keeps err_ack high for the whole transaction.
    task automatic send(input logic [WL-1:0] d, input int nak, input bit hold,
                        input bit mid_data, input int err_off, input int err_len,
                        output int acc);
        int waited = 0;
        int retries;
        bit failing;
        int off, len;
        while (!tx_ready && waited < 400) begin
            @(negedge t_clk);
            waited++;
        end
        if (!tx_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: got tx_ready=0 after %0d cycles, expected 1", waited);
            acc = -1;
            return;
        end
        if (hold) err_ack = 1'b1;
        tx_data  = d;
        tx_valid = 1'b1;
        acc      = cyc + 1;
        failing  = hold || (nak > MR);
        retries  = failing ? MR : nak;
        for (int r = 0; r <= retries; r++) exp_q.push_back(d);
        exp_kind_q.push_back(failing ? 2 : 1);
        exp_retry_q.push_back(retries);
        exp_cyc_q.push_back(acc + TXN * (retries + 1));
        @(negedge t_clk);
        tx_valid = 1'b0;
        tx_data  = WL'($urandom);
        if (mid_data) begin
            wait_cyc(acc + 10);
            tx_valid = 1'b1;
            tx_data  = ~d;
            for (int k = 0; k < 2; k++) begin
                @(negedge t_clk);
                check("ready_in_data", 64'(tx_ready), 64'd0);
            end
            tx_valid = 1'b0;
        end
        for (int j = 0; j < nak && j <= MR; j++) begin
            off = (err_off < 0) ? int'($urandom_range(43, 49)) : err_off;
            len = (err_len < 1) ? int'($urandom_range(1, 3)) : err_len;
            wait_cyc(acc + TXN * j + off);
            err_ack = 1'b1;
            repeat (len) @(negedge t_clk);
            err_ack = 1'b0;
        end
        if (hold) begin
            wait_cyc(acc + TXN * (MR + 1));
            err_ack = 1'b0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int a1, a2, a3;
        int pick, nak, waited;
        logic [WL-1:0] d;

        // Reset state
        repeat (3) @(negedge t_clk);
        check("rst_line", 64'(UART_Tx_OUT), 64'd1);
        check("rst_ready", 64'(tx_ready), 64'd1);
        check("rst_busy", 64'(tx_busy), 64'd0);
        check("rst_done", 64'(tx_done), 64'd0);
        check("rst_fail", 64'(tx_fail), 64'd0);
        check("rst_retry", 64'(retry_cnt), 64'd0);
        t_rst_n = 1'b1;
        @(negedge t_clk);

        // Basic frame, then back-to-back pair
        send(8'hA5, 0, 1'b0, 1'b0, -1, 0, a1);
        send(8'h07, 0, 1'b0, 1'b0, -1, 0, a1);
        send(8'h3C, 0, 1'b0, 1'b0, -1, 0, a2);
        check("back_to_back", 64'(a2), 64'(a1 + TXN + 1));

        // One NAK of 3 cycles inside the first window -> one resend then done
        send(WL'($urandom), 1, 1'b0, 1'b0, 45, 3, a1);

        // err_ack held -> three frames then fail; retry_cnt holds afterwards
        send(WL'($urandom), 0, 1'b1, 1'b0, -1, 0, a1);
        repeat (3) @(negedge t_clk);
        check("retry_hold", 64'(retry_cnt), 64'd2);

        // New tx_valid/tx_data mid-DATA must not disturb the frame
        send(WL'($urandom), 0, 1'b0, 1'b1, -1, 0, a1);

        // Reset during PARITY: pick a word whose parity bit is 0
        d = WL'($urandom);
        while ($countones(d) % 2 == 0) d = WL'($urandom);
        send(d, 0, 1'b0, 1'b0, -1, 0, a3);
        if (a3 >= 0) begin
            wait_cyc(a3 + 37);
            check("line_parity", 64'(UART_Tx_OUT), 64'd0);
            check("busy_in_frame", 64'(tx_busy), 64'd1);
            @(posedge t_clk);
            #2;
            t_rst_n = 1'b0;
            #1;
            check("line_async_reset", 64'(UART_Tx_OUT), 64'd1);
            check("ready_async_reset", 64'(tx_ready), 64'd1);
            exp_q.delete();
            exp_kind_q.delete();
            exp_retry_q.delete();
            exp_cyc_q.delete();
            repeat (2) @(negedge t_clk);
            t_rst_n = 1'b1;
            @(negedge t_clk);
            check("ready_after_release", 64'(tx_ready), 64'd1);
            check("retry_after_release", 64'(retry_cnt), 64'd0);
            repeat (60) @(negedge t_clk);
        end

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge t_clk);
            pick = int'($urandom_range(0, 9));
            nak  = (pick < 5) ? 0 : (pick < 8) ? 1 : (pick == 8) ? 2 : 3;
            send(WL'($urandom), nak, 1'b0, 1'b0, -1, 0, a1);
        end

        // Drain
        waited = 0;
        while ((exp_q.size() != 0 || exp_kind_q.size() != 0) && waited < 800) begin
            @(negedge t_clk);
            waited++;
        end
        repeat (5) @(negedge t_clk);
        check("drain_frames", 64'(exp_q.size()), 64'd0);
        check("drain_results", 64'(exp_kind_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
